mem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: instruction fetch (IF) and the load/store unit (LSU).
- Accepts one request at a time, issues it on the memory port, waits for the response, and routes it back to the owner.
- Sits between the core front-end/LSU and the unified memory. Only one transaction is outstanding at any time.

---
 rtl/nano_mem_pkg.sv | 26 ++
 rtl/arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_mem_pkg.sv
// ============================================================================
// nano_mem_pkg : shared types and constants for the memory-port arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package nano_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  // Wide enough for any realistic byte-enable width; users slice the low bits.
  localparam logic [63:0] BE_FULL = '1;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// arb_pick : combinational one-hot winner select between IF and LSU
//            (MEM_ARB_ROUND_ROBIN_EN enables alternating priority)
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_pick (
  input  logic       if_req,
  input  logic       lsu_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [1:0] last_owner,
`endif
  output logic [1:0] win          // bit 0 = IF, bit 1 = LSU
);
  import nano_mem_pkg::*;

  always_comb begin
    win = 2'b00;
    if (if_req && lsu_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // the requester that was not served last goes first
      win = (last_owner == OWN_LSU) ? 2'b01 : 2'b10;
`else
      win = 2'b10;
`endif
    end else if (lsu_req) begin
      win = 2'b10;
    end else if (if_req) begin
      win = 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory port between instruction fetch and the LSU,
//               one outstanding transaction (MEM_ARB_ROUND_ROBIN_EN optional)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [BE_W-1:0]   lsu_be_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);
  import nano_mem_pkg::*;

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        win;
  logic              accept;
  logic              resp;
  logic              live;
  logic              issuing;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t            last_owner_q;
`endif

  arb_pick u_pick (
    .if_req     (if_req_i),
    .lsu_req    (lsu_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_owner (last_owner_q),
`endif
    .win        (win)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win != 2'b00) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            resp    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (win[1]) begin
          owner_q <= OWN_LSU;
          addr_q  <= lsu_addr_i;
          we_q    <= lsu_we_i;
          be_q    <= lsu_be_i;
          wdata_q <= lsu_wdata_i;
        end else begin
          owner_q <= OWN_IF;
          addr_q  <= if_addr_i;
          we_q    <= 1'b0;
          be_q    <= BE_FULL[BE_W-1:0];
          wdata_q <= '0;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_q <= win[1] ? OWN_LSU : OWN_IF;
`endif
      end else if (resp) begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // Outputs are forced low while reset is held so nothing leaks mid-reset.
  assign live    = ~rst_i;
  assign issuing = live & (state_q == ISSUE);

  assign if_gnt_o     = live & accept & win[0];
  assign lsu_gnt_o    = live & accept & win[1];
  assign busy_o       = live & (state_q != IDLE);

  assign mem_req_o    = issuing;
  assign mem_we_o     = issuing & we_q;
  assign mem_be_o     = issuing ? be_q    : '0;
  assign mem_addr_o   = issuing ? addr_q  : '0;
  assign mem_wdata_o  = issuing ? wdata_q : '0;

  assign if_rvalid_o  = live & resp & (owner_q == OWN_IF);
  assign lsu_rvalid_o = live & resp & (owner_q == OWN_LSU);
  assign if_rdata_o   = if_rvalid_o  ? mem_rdata_i : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : randomized bench for mem_arbiter with a transaction-level
//                  reference model and a simple memory slave
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0, lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, lsu_addr_i = '0, lsu_wdata_i = '0;
  logic [3:0]  lsu_be_i = '0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] if_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o, busy_o;
  logic [3:0]  mem_be_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // golden memory (updated when a store is granted) and slave backing store
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  // requesters
  bit          if_pend = 0, lsu_pend = 0, l_we = 0;
  logic [31:0] if_a = '0, l_a = '0, l_wd = '0;
  logic [3:0]  l_be = '0;

  // memory slave
  int          d_cnt = 0, w_cnt = 0, cfg_gd = 0, cfg_lat = 1;
  bit          rnd_cfg = 0, stray_en = 0;
  logic [31:0] s_rd = '0;

  // reference transaction model: phase 0 idle, 1 request on port, 2 awaiting data
  int          m_phase = 0, m_own = 0, m_last = 1;
  logic [31:0] m_a = '0, m_wd = '0;
  logic [3:0]  m_be = '0;
  bit          m_we = 0;

  int          gq[$];
  logic [31:0] last_if_d = '0, last_lsu_d = '0;
  int          mreq_cnt = 0, gnt_cnt = 0, if_rv_cnt = 0, lsu_rv_cnt = 0;

  task automatic set_cfg(input int gd, input int lat);
    cfg_gd = gd; cfg_lat = lat; d_cnt = gd;
  endtask

  task automatic cycle();
    bit resp_now, legit, gi, gl, rv_i, rv_l;
    @(negedge clk);
    if_req_i = if_pend; if_addr_i = if_a;
    lsu_req_i = lsu_pend; lsu_we_i = l_we; lsu_be_i = l_be;
    lsu_addr_i = l_a; lsu_wdata_i = l_wd;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom; resp_now = 0;
    if (w_cnt > 0) begin
      w_cnt--;
      if (w_cnt == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = s_rd; resp_now = 1; end
    end else if (mem_req_o) begin
      if (d_cnt > 0) begin
        d_cnt--;
        if (stray_en && $urandom_range(0, 3) == 0) mem_rvalid_i = 1'b1;
      end else begin
        mem_gnt_i = 1'b1;
        s_rd = mem_we_o ? $urandom : slv_rd(mem_addr_o);
        if (mem_we_o) slv_mem[mem_addr_o] = merge(slv_rd(mem_addr_o), mem_wdata_o, mem_be_o);
        if (cfg_lat == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = s_rd; resp_now = 1; end
        else w_cnt = cfg_lat;
        if (rnd_cfg) begin cfg_gd = $urandom_range(0, 3); cfg_lat = $urandom_range(0, 3); end
        d_cnt = cfg_gd;
      end
    end else if (stray_en && $urandom_range(0, 3) == 0) begin
      mem_rvalid_i = 1'b1;
    end
    #1;
    if (rst_i) begin
      chk("rst_if_gnt", if_gnt_o, 0);       chk("rst_lsu_gnt", lsu_gnt_o, 0);
      chk("rst_busy", busy_o, 0);           chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);       chk("rst_mem_be", mem_be_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);   chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_if_rvalid", if_rvalid_o, 0); chk("rst_lsu_rvalid", lsu_rvalid_o, 0);
      chk("rst_if_rdata", if_rdata_o, 0);   chk("rst_lsu_rdata", lsu_rdata_o, 0);
      m_phase = 0; m_last = 1;
      return;
    end
    gi = 0; gl = 0;
    if (m_phase == 0) begin
      if (if_req_i && lsu_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (m_last == 1) gl = 1; else gi = 1;
`else
        gl = 1;
`endif
      end else begin
        gi = if_req_i; gl = lsu_req_i;
      end
    end
    chk("if_gnt", if_gnt_o, gi);
    chk("lsu_gnt", lsu_gnt_o, gl);
    chk("busy", busy_o, m_phase != 0);
    chk("mem_req", mem_req_o, m_phase == 1);
    if (m_phase == 1) begin
      chk("mem_addr", mem_addr_o, m_a);
      chk("mem_we", mem_we_o, m_we);
      chk("mem_be", mem_be_o, m_be);
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wd);
    end
    legit = resp_now && (m_phase == 2 || (m_phase == 1 && mem_gnt_i));
    rv_i = legit && m_own == 1;
    rv_l = legit && m_own == 2;
    chk("if_rvalid", if_rvalid_o, rv_i);
    chk("lsu_rvalid", lsu_rvalid_o, rv_l);
    if (rv_i) chk("if_rdata", if_rdata_o, ref_rd(m_a));
    if (rv_l) chk("lsu_rdata", lsu_rdata_o, m_we ? mem_rdata_i : ref_rd(m_a));
    if (m_phase != 0 && m_own == 2) chk("if_rdata_idle", if_rdata_o, 0);
    if (m_phase != 0 && m_own == 1) chk("lsu_rdata_idle", lsu_rdata_o, 0);
    if (rv_i) begin last_if_d = if_rdata_o; if_rv_cnt++; end
    if (rv_l) begin last_lsu_d = lsu_rdata_o; lsu_rv_cnt++; end
    if (if_rvalid_o) if_rv_cnt += rv_i ? 0 : 1;
    if (lsu_rvalid_o) lsu_rv_cnt += rv_l ? 0 : 1;
    if (mem_req_o) mreq_cnt++;
    if (if_gnt_o || lsu_gnt_o) gnt_cnt++;
    if (legit) m_phase = 0;
    else if (m_phase == 1 && mem_gnt_i) m_phase = 2;
    if (gi || gl) begin
      m_phase = 1; m_own = gl ? 2 : 1; m_last = m_own; gq.push_back(m_own);
      if (gl) begin
        m_a = l_a; m_we = l_we; m_be = l_be; m_wd = l_wd; lsu_pend = 0;
        if (l_we) ref_mem[l_a] = merge(ref_rd(l_a), l_wd, l_be);
      end else begin
        m_a = if_a; m_we = 0; m_be = 4'hF; m_wd = '0; if_pend = 0;
      end
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((if_pend || lsu_pend || m_phase != 0) && n < maxc) begin cycle(); n++; end
    chk("idle_within_budget", n < maxc, 1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cycle(); cycle(); rst_i = 1'b0;
  endtask

  task automatic arm_lsu(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    lsu_pend = 1; l_we = we; l_a = a; l_wd = wd; l_be = be;
  endtask

  initial begin
    int c0, c1, c2;
    do_reset();

    // IF fetch, immediate grant, data two cycles later
    slv_mem[32'h100] = 32'h13; ref_mem[32'h100] = 32'h13;
    set_cfg(0, 2);
    c0 = if_rv_cnt; c1 = lsu_rv_cnt;
    if_pend = 1; if_a = 32'h100;
    wait_idle(20);
    chk("fetch_data", last_if_d, 32'h13);
    chk("fetch_if_rv_count", if_rv_cnt - c0, 1);
    chk("fetch_lsu_rv_count", lsu_rv_cnt - c1, 0);

    // store then load back
    c0 = lsu_rv_cnt;
    arm_lsu(1, 32'h4, 32'hDEADBEEF, 4'hF);
    wait_idle(20);
    chk("store_ack", lsu_rv_cnt - c0, 1);
    arm_lsu(0, 32'h4, 32'h0, 4'h0);
    wait_idle(20);
    chk("load_data", last_lsu_d, 32'hDEADBEEF);

    // simultaneous requests, four back-to-back pairs
    do_reset();
    set_cfg(0, 1);
    gq.delete();
    for (int p = 0; p < 4; p++) begin
      if_pend = 1; if_a = 32'h200;
      arm_lsu(0, 32'h8, 32'h0, 4'h0);
      wait_idle(40);
    end
    chk("pair_grants", gq.size(), 8);
    for (int k = 0; k < gq.size() && k < 8; k++)
      chk($sformatf("pair_order_%0d", k), gq[k], (k % 2 == 0) ? 2 : 1);

    // grant stall of five cycles, IF keeps requesting
    set_cfg(5, 1);
    if_pend = 1; if_a = 32'h40;
    cycle();
    if_pend = 1; if_a = 32'h44;
    c0 = mreq_cnt; c1 = gnt_cnt;
    for (int i = 0; i < 7; i++) cycle();
    chk("stall_mem_req_cycles", mreq_cnt - c0, 6);
    chk("stall_no_gnt", gnt_cnt - c1, 0);
    set_cfg(0, 1);
    wait_idle(40);

    // same-cycle grant and response
    set_cfg(0, 0);
    c0 = lsu_rv_cnt;
    arm_lsu(0, 32'h4, 32'h0, 4'h0);
    cycle(); cycle();
    chk("same_cycle_rv", lsu_rv_cnt - c0, 1);
    cycle();
    chk("same_cycle_idle", busy_o, 0);

    // reset while waiting for data, then the stale response arrives
    set_cfg(0, 6);
    c0 = if_rv_cnt; c1 = lsu_rv_cnt;
    if_pend = 1; if_a = 32'h100;
    cycle(); cycle(); cycle();
    c2 = busy_o;
    chk("wait_busy", c2, 1);
    rst_i = 1'b1; cycle(); cycle(); rst_i = 1'b0;
    stray_en = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("post_rst_if_rv", if_rv_cnt - c0, 0);
    chk("post_rst_lsu_rv", lsu_rv_cnt - c1, 0);
    chk("post_rst_busy", busy_o, 0);

    // randomized traffic with random memory timing and stray responses
    do_reset();
    rnd_cfg = 1; stray_en = 1; set_cfg(1, 1);
    for (int i = 0; i < 3000; i++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_a = 32'($urandom_range(0, 15)) << 2;
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0)
        arm_lsu($urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)) << 2,
                $urandom, 4'($urandom_range(0, 15)));
      cycle();
    end
    wait_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
